excp_int_ctrl: RTL and testbench

//  Registered exception/interrupt/ERTN commit unit at the mem1 boundary. Adds NUM_HWI-wide HWI

---
 rtl/excp_int_ctrl.sv | 177 +++++++++++++++++
 tb/tb_excp_int_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/excp_int_ctrl.sv
// Exception / interrupt / ERTN commit unit at the mem1 boundary with an internal stable timer.
// Optional macro EXCP_HWI_SYNC_EN: two-flop synchronizer on hwi_in instead of a single register.
module excp_int_ctrl #(
    parameter int NUM_HWI      = 8,
    parameter int TIMER_W      = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_HWI-1:0] hwi_in,
    input  logic               req_valid,
    input  logic               req_excp,
    input  logic [14:0]        req_ecode,
    input  logic               req_ertn,
    input  logic [31:0]        req_epc,
    input  logic               req_badv_vld,
    input  logic [31:0]        req_badv,
    input  logic [1:0]         crmd_plv,
    input  logic               crmd_ie,
    input  logic [1:0]         prmd_pplv,
    input  logic               prmd_pie,
    input  logic [12:0]        ecfg_lie,
    input  logic [1:0]         estat_swi,
    input  logic [31:0]        era,
    input  logic [31:0]        eentry,
    input  logic [31:0]        tlbrentry,
    input  logic               tcfg_we,
    input  logic [TIMER_W-1:0] tcfg_wdata,
    input  logic               ticlr_we,
    output logic [TIMER_W-1:0] tval,
    output logic               excp_flush,
    output logic               wr_pc_valid,
    output logic [31:0]        wr_pc,
    output logic               csr_we,
    output logic [1:0]         new_plv,
    output logic               new_ie,
    output logic [1:0]         new_pplv,
    output logic               new_pie,
    output logic [31:0]        new_era,
    output logic [14:0]        new_ecode,
    output logic               ecode_we,
    output logic [12:0]        new_is,
    output logic               badv_we,
    output logic [31:0]        new_badv
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_DRAIN} state_t;

    state_t            state;
    logic [DW-1:0]     drain_cnt;
    logic [NUM_HWI-1:0] hwi_q;
    logic [7:0]        hwi_ext;
    logic [12:0]       int_vec;
    logic              int_pend, accept;
    logic              t_en, t_per, ti, timeout;
    logic [TIMER_W-3:0] t_init;

`ifdef EXCP_HWI_SYNC_EN
    logic [NUM_HWI-1:0] hwi_meta;
    always_ff @(posedge clk) begin
        if (rst) begin
            hwi_meta <= '0;
            hwi_q    <= '0;
        end else begin
            hwi_meta <= hwi_in;
            hwi_q    <= hwi_meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) hwi_q <= '0;
        else     hwi_q <= hwi_in;
    end
`endif

    always_comb begin
        hwi_ext = '0;
        hwi_ext[NUM_HWI-1:0] = hwi_q;
    end

    assign int_vec  = {1'b0, ti, 1'b0, hwi_ext, estat_swi};
    assign int_pend = crmd_ie & |(int_vec & ecfg_lie);
    assign accept   = (state == S_IDLE) && req_valid && (int_pend || req_excp || req_ertn);
    assign timeout  = t_en && (tval == TIMER_W'(1));

    // A TCFG write overrides the countdown, but a timeout in the same cycle still raises ti.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_en   <= 1'b0;
            t_per  <= 1'b0;
            t_init <= '0;
            tval   <= '0;
            ti     <= 1'b0;
        end else begin
            if (tcfg_we) begin
                t_en   <= tcfg_wdata[0];
                t_per  <= tcfg_wdata[1];
                t_init <= tcfg_wdata[TIMER_W-1:2];
                tval   <= {tcfg_wdata[TIMER_W-1:2], 2'b00};
            end else if (t_en) begin
                if (tval != '0)  tval <= tval - TIMER_W'(1);
                else if (t_per)  tval <= {t_init, 2'b00};
            end
            if (timeout)       ti <= 1'b1;
            else if (ticlr_we) ti <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE:   if (accept) state <= S_COMMIT;
                S_COMMIT: begin
                    state     <= S_DRAIN;
                    drain_cnt <= DW'(DRAIN_CYCLES - 1);
                end
                S_DRAIN:  begin
                    if (drain_cnt == '0) state <= S_IDLE;
                    else                 drain_cnt <= drain_cnt - DW'(1);
                end
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Commit outputs are zero by default and only carry a decision in the cycle after accept.
    always_ff @(posedge clk) begin
        excp_flush  <= 1'b0;
        wr_pc_valid <= 1'b0;
        csr_we      <= 1'b0;
        wr_pc       <= '0;
        new_plv     <= '0;
        new_ie      <= 1'b0;
        new_pplv    <= '0;
        new_pie     <= 1'b0;
        new_era     <= '0;
        new_ecode   <= '0;
        ecode_we    <= 1'b0;
        new_is      <= '0;
        badv_we     <= 1'b0;
        new_badv    <= '0;
        if (!rst && accept) begin
            excp_flush  <= 1'b1;
            wr_pc_valid <= 1'b1;
            csr_we      <= 1'b1;
            new_is      <= int_vec;
            if (int_pend || req_excp) begin
                new_plv  <= 2'd0;
                new_ie   <= 1'b0;
                new_pplv <= crmd_plv;
                new_pie  <= crmd_ie;
                new_era  <= req_epc;
                ecode_we <= 1'b1;
                if (int_pend) begin
                    wr_pc <= eentry;
                end else begin
                    wr_pc     <= (req_ecode[5:0] == ECODE_TLBR) ? tlbrentry : eentry;
                    new_ecode <= req_ecode;
                    badv_we   <= req_badv_vld;
                    new_badv  <= req_badv_vld ? req_badv : 32'd0;
                end
            end else begin
                new_plv  <= prmd_pplv;
                new_ie   <= prmd_pie;
                new_pplv <= prmd_pplv;
                new_pie  <= prmd_pie;
                new_era  <= era;
                wr_pc    <= era;
            end
        end
    end
endmodule

// File: tb/tb_excp_int_ctrl.sv
// Bench for excp_int_ctrl: directed scenarios then random traffic against a cycle-count based model.
module tb_excp_int_ctrl;
    localparam int NUM_HWI = 8;
    localparam int TIMER_W = 32;
    localparam int DRAIN   = 2;
`ifdef EXCP_HWI_SYNC_EN
    localparam int HLAT = 2;
`else
    localparam int HLAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [NUM_HWI-1:0] hwi_in;
    logic req_valid, req_excp, req_ertn, req_badv_vld;
    logic [14:0] req_ecode;
    logic [31:0] req_epc, req_badv, era, eentry, tlbrentry;
    logic [1:0]  crmd_plv, prmd_pplv, estat_swi;
    logic        crmd_ie, prmd_pie, tcfg_we, ticlr_we;
    logic [12:0] ecfg_lie;
    logic [TIMER_W-1:0] tcfg_wdata, tval;
    logic excp_flush, wr_pc_valid, csr_we, new_ie, new_pie, ecode_we, badv_we;
    logic [31:0] wr_pc, new_era, new_badv;
    logic [1:0]  new_plv, new_pplv;
    logic [14:0] new_ecode;
    logic [12:0] new_is;

    always #5 clk = ~clk;

    excp_int_ctrl #(.NUM_HWI(NUM_HWI), .TIMER_W(TIMER_W), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst), .hwi_in(hwi_in), .req_valid(req_valid), .req_excp(req_excp),
        .req_ecode(req_ecode), .req_ertn(req_ertn), .req_epc(req_epc), .req_badv_vld(req_badv_vld),
        .req_badv(req_badv), .crmd_plv(crmd_plv), .crmd_ie(crmd_ie), .prmd_pplv(prmd_pplv),
        .prmd_pie(prmd_pie), .ecfg_lie(ecfg_lie), .estat_swi(estat_swi), .era(era),
        .eentry(eentry), .tlbrentry(tlbrentry), .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
        .ticlr_we(ticlr_we), .tval(tval), .excp_flush(excp_flush), .wr_pc_valid(wr_pc_valid),
        .wr_pc(wr_pc), .csr_we(csr_we), .new_plv(new_plv), .new_ie(new_ie), .new_pplv(new_pplv),
        .new_pie(new_pie), .new_era(new_era), .new_ecode(new_ecode), .ecode_we(ecode_we),
        .new_is(new_is), .badv_we(badv_we), .new_badv(new_badv)
    );

    typedef struct packed {
        logic        flush;
        logic [31:0] pc;
        logic [1:0]  plv;
        logic        ie;
        logic [1:0]  pplv;
        logic        pie;
        logic [31:0] era;
        logic [14:0] ecode;
        logic        ecode_we;
        logic [12:0] is_v;
        logic        badv_we;
        logic [31:0] badv;
    } exp_t;

    int total = 0;
    int bad = 0;

    // Reference state: the busy window is tracked as "next edge that may accept", the timer as
    // (config, edges since last write) with tval derived arithmetically.
    int     edge_n = 0;
    int     ready_edge = 0;
    logic [7:0] h1 = '0, h2 = '0;
    bit     m_en, m_per, m_ti;
    longint m_init4, m_k;
    exp_t   ex;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [TIMER_W-1:0] tval_of();
        longint v;
        if (!m_en || m_init4 == 0) v = m_init4;
        else if (m_per)            v = m_init4 - (m_k % (m_init4 + 1));
        else                       v = (m_k >= m_init4) ? 0 : m_init4 - m_k;
        return TIMER_W'(v);
    endfunction

    task automatic tick();
        exp_t n;
        logic [12:0] iv;
        logic [7:0]  hq;
        bit ip, to;
        n = '0;
        if (rst) begin
            m_en = 0; m_per = 0; m_init4 = 0; m_k = 0; m_ti = 0;
            h1 = '0; h2 = '0;
            ready_edge = edge_n + 1;
        end else begin
            hq = (HLAT == 2) ? h2 : h1;
            iv = {1'b0, m_ti, 1'b0, hq, estat_swi};
            ip = crmd_ie && ((iv & ecfg_lie) != 13'd0);
            if (edge_n >= ready_edge && req_valid && (ip || req_excp || req_ertn)) begin
                n.flush = 1'b1;
                n.is_v  = iv;
                if (ip || req_excp) begin
                    n.pplv = crmd_plv; n.pie = crmd_ie; n.era = req_epc; n.ecode_we = 1'b1;
                    if (ip) n.pc = eentry;
                    else begin
                        n.pc = (req_ecode[5:0] == 6'h3F) ? tlbrentry : eentry;
                        n.ecode   = req_ecode;
                        n.badv_we = req_badv_vld;
                        n.badv    = req_badv_vld ? req_badv : 32'd0;
                    end
                end else begin
                    n.pc = era; n.plv = prmd_pplv; n.ie = prmd_pie;
                    n.pplv = prmd_pplv; n.pie = prmd_pie; n.era = era;
                end
                ready_edge = edge_n + DRAIN + 2;
            end
            m_k++;
            to = m_en && m_init4 != 0 &&
                 (m_per ? ((m_k % (m_init4 + 1)) == m_init4) : (m_k == m_init4));
            if (tcfg_we) begin
                m_en = tcfg_wdata[0]; m_per = tcfg_wdata[1];
                m_init4 = longint'({tcfg_wdata[TIMER_W-1:2], 2'b00});
                m_k = 0;
            end
            if (to) m_ti = 1;
            else if (ticlr_we) m_ti = 0;
            h2 = h1; h1 = hwi_in;
        end
        ex = n;
        @(posedge clk); #1;
        edge_n++;
        chk("ctl", {excp_flush, wr_pc_valid, csr_we, ecode_we, badv_we},
                   {ex.flush, ex.flush, ex.flush, ex.ecode_we, ex.badv_we});
        chk("wr_pc", wr_pc, ex.pc);
        chk("crmd_prmd", {new_plv, new_ie, new_pplv, new_pie}, {ex.plv, ex.ie, ex.pplv, ex.pie});
        chk("era", new_era, ex.era);
        chk("ecode", new_ecode, ex.ecode);
        chk("is", new_is, ex.is_v);
        chk("badv", new_badv, ex.badv);
        chk("tval", tval, tval_of());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1; hwi_in = '0; req_valid = 0; req_excp = 0; req_ertn = 0; req_badv_vld = 0;
        req_ecode = '0; req_epc = '0; req_badv = '0; crmd_plv = 0; crmd_ie = 0; prmd_pplv = 0;
        prmd_pie = 0; ecfg_lie = '0; estat_swi = '0; era = 32'h1C0000F0; eentry = 32'h1C008000;
        tlbrentry = 32'h1C00F000; tcfg_we = 0; tcfg_wdata = '0; ticlr_we = 0;
        ticks(2);
        rst = 0;
        tick();

        // HWI interrupt
        crmd_ie = 1; ecfg_lie = 13'h004; hwi_in = 8'h01;
        ticks(HLAT);
        req_valid = 1; req_epc = 32'h1C000100;
        tick();
        chk("t1_flush", excp_flush, 1'b1);
        chk("t1_pc", wr_pc, 32'h1C008000);
        chk("t1_era", new_era, 32'h1C000100);
        chk("t1_is2", new_is[2], 1'b1);
        req_valid = 0; hwi_in = '0; ecfg_lie = '0;
        ticks(DRAIN + 2);

        // TLB refill exception with BADV
        crmd_plv = 3; req_valid = 1; req_excp = 1; req_ecode = 15'h003F;
        req_badv_vld = 1; req_badv = 32'hDEAD0000; req_epc = 32'h1C000200;
        tick();
        chk("t2_pc", wr_pc, 32'h1C00F000);
        chk("t2_badv", {badv_we, new_badv}, {1'b1, 32'hDEAD0000});
        chk("t2_plv", {new_plv, new_pplv}, {2'd0, 2'd3});
        req_valid = 0; req_excp = 0; req_badv_vld = 0;
        ticks(DRAIN + 2);

        // ERTN
        prmd_pplv = 3; prmd_pie = 1; req_valid = 1; req_ertn = 1;
        tick();
        chk("t3_pc", wr_pc, 32'h1C0000F0);
        chk("t3_plv_ie", {new_plv, new_ie}, {2'd3, 1'b1});
        req_valid = 0; req_ertn = 0;
        ticks(DRAIN + 2);

        // Periodic timer, InitVal=2
        tcfg_we = 1; tcfg_wdata = 32'h0000_000B;
        tick();
        tcfg_we = 0;
        chk("t4_load", tval, 32'd8);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t4_count", tval, 32'(8 - i));
        end
        tick();
        chk("t4_reload", tval, 32'd8);
        ticlr_we = 1;
        tick();
        ticlr_we = 0;
        ticks(6);
        chk("t4_pre", tval, 32'd1);
        ticlr_we = 1;
        tick();
        ticlr_we = 0;
        ecfg_lie = 13'h800; req_valid = 1;
        tick();
        chk("t4_ti_int", {excp_flush, new_is[11], new_ecode}, {1'b1, 1'b1, 15'd0});
        req_valid = 0; ecfg_lie = '0; tcfg_we = 1; tcfg_wdata = '0;
        tick();
        tcfg_we = 0;
        ticks(DRAIN + 1);

        // Interrupt beats exception; requests during drain ignored
        ecfg_lie = 13'h004; hwi_in = 8'h01;
        ticks(HLAT);
        req_valid = 1; req_excp = 1; req_ecode = 15'h0008;
        tick();
        chk("t5_int", {excp_flush, ecode_we, new_ecode}, {1'b1, 1'b1, 15'd0});
        for (int i = 0; i < DRAIN + 1; i++) begin
            tick();
            chk("t5_drain", excp_flush, 1'b0);
        end
        req_valid = 0; req_excp = 0; hwi_in = '0; ecfg_lie = '0;
        ticks(2);

        // Reset during COMMIT
        tcfg_we = 1; tcfg_wdata = 32'h0000_0041;
        tick();
        tcfg_we = 0;
        ticks(3);
        req_valid = 1; req_excp = 1; req_ecode = 15'h0005;
        tick();
        chk("t6_commit", excp_flush, 1'b1);
        rst = 1; req_valid = 0;
        tick();
        chk("t6_rst", {excp_flush, csr_we, wr_pc, tval}, 66'd0);
        rst = 0; req_valid = 1;
        tick();
        chk("t6_idle", excp_flush, 1'b1);
        req_valid = 0; req_excp = 0;
        ticks(DRAIN + 2);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            req_valid    = ($urandom_range(0, 9) < 4);
            req_excp     = ($urandom_range(0, 9) < 3);
            req_ertn     = ($urandom_range(0, 9) < 2);
            req_ecode    = ($urandom_range(0, 3) == 0) ? 15'h003F : 15'($urandom);
            req_epc      = $urandom;
            req_badv_vld = $urandom_range(0, 1);
            req_badv     = $urandom;
            hwi_in       = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            crmd_plv     = 2'($urandom); crmd_ie = $urandom_range(0, 1);
            prmd_pplv    = 2'($urandom); prmd_pie = $urandom_range(0, 1);
            ecfg_lie     = 13'($urandom);
            estat_swi    = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            era          = $urandom; eentry = $urandom; tlbrentry = $urandom;
            tcfg_we      = ($urandom_range(0, 59) == 0);
            tcfg_wdata   = 32'(($urandom_range(0, 6) << 2) | ($urandom_range(0, 1) << 1)
                           | $urandom_range(0, 3) != 0);
            ticlr_we     = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
